idelay_ctrl_seq: RTL
====================

Name: idelay_ctrl_seq

Overview:
- Reset/ready sequencer for the IODELAY calibration controller wrapper; sits directly upstream of it.
- Drives the wrapper's active-high reset with a guaranteed-width pulse, synchronises and waits for its ready output, retries on timeout, and flags lost calibration.
- Its `ready` gates release of the memory PHY delay-tap training logic.
- Runs in the reference-clock domain.

Parameters:
- RST_CYCLES, 16: clk cycles `dly_rst` is held high per attempt; must be ≥1 and <2^CNT_W.
- RDY_TIMEOUT, 1024: WAIT-state cycles allowed before an attempt is declared failed; must be ≥3 and <2^CNT_W.
- MAX_RETRIES, 3: extra attempts after the first before entering FAIL.
- CNT_W, 16: width of the shared cycle counter.
- RETRY_W, 4: width of `retries`; 2^RETRY_W > MAX_RETRIES.

Ports:
- clk, input, 1: reference clock, same clock as the controller wrapper; all logic rising-edge.
- rst_n, input, 1: asynchronous active-low reset.
- restart, input, 1: synchronous pulse; restarts the sequence and clears status.
- rdy_in, input, 1: controller ready; treated as asynchronous.
- dly_rst, output, 1: active-high reset to the controller wrapper.
- ready, output, 1: calibration valid.
- fail, output, 1: sticky; all attempts timed out.
- lost, output, 1: sticky; ready dropped while in READY.
- retries, output, RETRY_W: retry attempts consumed in the current sequence.
- state, output, 2: RESET=0, WAIT=1, READY=2, FAIL=3.

Behaviour:
- Reset values (rst_n low, asynchronous): state=RESET, cnt=0, dly_rst=1, ready=0, fail=0, lost=0, retries=0, sync flops=0.
- dly_rst is high while rst_n is low.
- rdy_s: rdy_in through a 2-FF synchroniser; these flops are never cleared except by rst_n.
- All outputs are registered or decoded directly from registered state.
  - dly_rst = (state==RESET)
  - ready = (state==READY)
  - fail = (state==FAIL)
- RESET:
  - cnt increments each cycle.
  - When cnt==RST_CYCLES-1: state→WAIT, cnt→0.
  - dly_rst is high for exactly RST_CYCLES cycles per entry.
  - rdy_s is ignored.
- WAIT:
  - cnt increments each cycle.
  - rdy_s is ignored while cnt<2, to flush stale synchroniser contents.
  - If cnt≥2 and rdy_s=1: state→READY.
  - Else if cnt==RDY_TIMEOUT-1:
    - if retries==MAX_RETRIES: state→FAIL.
    - else: retries+1, state→RESET, cnt→0.
  - rdy_s high in the same cycle as the timeout: READY wins.
- READY:
  - If rdy_s=0: lost→1, retries→0, state→RESET, cnt→0.
  - Otherwise stay.
- FAIL:
  - dly_rst=0; hold state until restart or rst_n.
- restart=1 in any state has top priority:
  - next state=RESET, cnt→0, retries→0, fail→0 (via state), lost→0.
  - In RESET, restart reloads cnt, lengthening the pulse.
- Latency: rdy_in first sampled high at edge E0 (with WAIT cnt≥2 at E2) → ready=1 after edge E2.
- rdy_in falling, sampled at edge E0 while in READY → ready=0, dly_rst=1 after edge E2.
- retries saturates at MAX_RETRIES and never wraps.

Test Plan:
Bench parameters for all scenarios: RST_CYCLES=4, RDY_TIMEOUT=8, MAX_RETRIES=2.
1. Release rst_n with rdy_in held 1 → dly_rst high 4 cycles after release; ready=1 at WAIT cnt=2, i.e. 3 edges after dly_rst falls; retries=0.
2. rdy_in held 0 → three dly_rst pulses of 4 cycles, each followed by 8 WAIT cycles; retries steps 0,1,2; then state=FAIL, fail=1, dly_rst=0, held indefinitely.
3. From FAIL, pulse restart for 1 cycle with rdy_in=1 → fail=0, retries=0, 4-cycle dly_rst pulse, then ready=1.
4. In READY, drop rdy_in for 3 cycles → ready falls 2 edges later; lost=1 (sticky); new 4-cycle dly_rst pulse; ready re-asserts once rdy_in returns; lost stays 1 until restart.
5. rdy_in rises so rdy_s=1 exactly at WAIT cnt=7 with retries=2 → state=READY, not FAIL; fail remains 0.
6. Assert rst_n low mid-WAIT with retries=1 → immediately dly_rst=1, retries=0, ready=0; after release, full 4-cycle pulse; restart asserted during RESET cnt=2 → dly_rst stays high 4 more cycles.

Source files
------------

// File: rtl/idelay_ctrl_seq.sv
// Reset/ready sequencer for the IODELAY calibration controller wrapper.
// Pulses dly_rst, waits for a synchronised ready, retries on timeout.
module idelay_ctrl_seq #(
  parameter int RST_CYCLES  = 16,
  parameter int RDY_TIMEOUT = 1024,
  parameter int MAX_RETRIES = 3,
  parameter int CNT_W       = 16,
  parameter int RETRY_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               restart,
  input  logic               rdy_in,
  output logic               dly_rst,
  output logic               ready,
  output logic               fail,
  output logic               lost,
  output logic [RETRY_W-1:0] retries,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2,
    S_FAIL  = 2'd3
  } st_t;

  st_t               st_q, st_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] rt_q, rt_d;
  logic               lost_q, lost_d;
  logic [1:0]         sync_q;
  logic               rdy_s;

  assign rdy_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], rdy_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= S_RESET;
      cnt_q  <= '0;
      rt_q   <= '0;
      lost_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      rt_q   <= rt_d;
      lost_q <= lost_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    rt_d   = rt_q;
    lost_d = lost_q;
    if (restart) begin
      st_d   = S_RESET;
      cnt_d  = '0;
      rt_d   = '0;
      lost_d = 1'b0;
    end else begin
      unique case (st_q)
        S_RESET: begin
          if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
            st_d  = S_WAIT;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT: begin
          cnt_d = cnt_q + CNT_W'(1);
          // first two cycles may still hold a stale synchroniser value
          if (cnt_q >= CNT_W'(2) && rdy_s) begin
            st_d  = S_READY;
            cnt_d = '0;
          end else if (cnt_q == CNT_W'(RDY_TIMEOUT - 1)) begin
            if (rt_q == RETRY_W'(MAX_RETRIES)) begin
              st_d = S_FAIL;
            end else begin
              rt_d  = rt_q + RETRY_W'(1);
              st_d  = S_RESET;
              cnt_d = '0;
            end
          end
        end
        S_READY: begin
          if (!rdy_s) begin
            lost_d = 1'b1;
            rt_d   = '0;
            st_d   = S_RESET;
            cnt_d  = '0;
          end
        end
        S_FAIL: begin
          st_d = S_FAIL;
        end
        default: begin
          st_d = S_RESET;
        end
      endcase
    end
  end

  assign dly_rst = (st_q == S_RESET);
  assign ready   = (st_q == S_READY);
  assign fail    = (st_q == S_FAIL);
  assign lost    = lost_q;
  assign retries = rt_q;
  assign state   = st_q;

endmodule
